// File: rtl/entry_ctrl.sv
// Player-entry sequencer for Bulls & Cows: conditions the enter button, collects four
// distinct 4-bit digits, hands the 16-bit entry over valid/ready and drives the entry display.
module entry_ctrl #(
  parameter int DEB_CNT   = 1_000_000,
  parameter int BLINK_CNT = 25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  code,
  input  logic        enter_button,
  input  logic        entry_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        err,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int BW = $clog2(BLINK_CNT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

  logic          s_meta, s, deb, deb_q, press;
  logic [DW-1:0] deb_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  state_t        state;
  logic [1:0]    idx;
  logic [3:0][3:0] dig;
  logic          dup;
  logic [3:0][5:0] disp;

  // deb only follows s after DEB_CNT consecutive disagreeing cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_meta  <= 1'b0;
      s       <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s_meta <= enter_button;
      s      <= s_meta;
      deb_q  <= deb;
      if (s == deb)
        deb_cnt <= '0;
      else if (deb_cnt == DW'(DEB_CNT - 1)) begin
        deb     <= s;
        deb_cnt <= '0;
      end else
        deb_cnt <= deb_cnt + DW'(1);
    end
  end

  assign press = deb & ~deb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_CNT - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else
      blink_cnt <= blink_cnt + BW'(1);
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++)
      if (2'(i) < idx && dig[i] == code) dup = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      dig       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (entry_req) begin
          state <= COLLECT;
          idx   <= '0;
          dig   <= '0;
          err   <= 1'b0;
        end
        COLLECT: begin
          // abort has priority over a coincident press
          if (!entry_req) begin
            state <= IDLE;
            idx   <= '0;
            dig   <= '0;
            err   <= 1'b0;
          end else if (press) begin
            if (dup)
              err <= 1'b1;
            else begin
              dig[idx] <= code;
              err      <= 1'b0;
              if (idx == 2'd3) begin
                state     <= PRESENT;
                idx       <= '0;
                out_valid <= 1'b1;
                out_data  <= {dig[0], dig[1], dig[2], code};
              end else
                idx <= idx + 2'd1;
            end
          end
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cursor shows the live switch value so the player sees what will be captured
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      disp[i] = '0;
      if (state == PRESENT)
        disp[i] = {1'b1, dig[i], 1'b0};
      else if (state == COLLECT) begin
        if (2'(i) < idx)       disp[i] = {1'b1, dig[i], 1'b0};
        else if (2'(i) == idx) disp[i] = {blink, code, err};
      end
    end
  end

  assign d1 = disp[0];
  assign d2 = disp[1];
  assign d3 = disp[2];
  assign d4 = disp[3];
endmodule

// File: tb/tb_entry_ctrl.sv
// Directed bench for entry_ctrl; completed entries are checked by a scoreboard monitor
// on each valid/ready transfer, display/err/latency by inline checks.
module tb_entry_ctrl;
  logic        clock, reset, enter_button, entry_req, out_ready, out_valid, err;
  logic [3:0]  code;
  logic [15:0] out_data;
  logic [5:0]  d1, d2, d3, d4;

  int checks = 0, errors = 0, npress = 0;
  logic [15:0] exp_q[$];

  entry_ctrl #(.DEB_CNT(4), .BLINK_CNT(8)) dut (
    .clock(clock), .reset(reset), .code(code), .enter_button(enter_button),
    .entry_req(entry_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err), .d1(d1), .d2(d2), .d3(d3), .d4(d4));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    code = c;
    enter_button = 1'b1;
    cyc(10);
    enter_button = 1'b0;
    cyc(10);
  endtask

  task automatic transfer(input logic [15:0] exp);
    exp_q.push_back(exp);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got transfer %h expected none", out_data);
      end else
        chk("sb_out_data", out_data, exp_q.pop_front());
    end
  end

  always @(negedge clock) if (dut.press) npress++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] v;
    logic ph;
    int n;
    clock = 0; reset = 0; code = 0; enter_button = 0; entry_req = 0; out_ready = 0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_disp", {d1, d2, d3, d4}, 0);
    cyc(1);
    reset = 1;
    cyc(2);

    // 1: debounce
    for (int i = 0; i < 10; i++) begin
      enter_button = ~enter_button;
      cyc(2);
    end
    chk("deb_glitch", npress, 0);
    enter_button = 1;
    cyc(10);
    chk("deb_press", npress, 1);
    enter_button = 0;
    cyc(10);
    chk("deb_release", npress, 1);

    // 2: normal entry
    entry_req = 1;
    cyc(2);
    press(1); press(2); press(3);
    chk("n_d1", d1, 6'b100010);
    chk("n_d2", d2, 6'b100100);
    chk("n_d3", d3, 6'b100110);
    code = 4; enter_button = 1;
    cyc(6);
    @(negedge clock);
    chk("lat_before", out_valid, 0);
    cyc(1);
    @(negedge clock);
    chk("lat_after", out_valid, 1);
    cyc(1);
    enter_button = 0;
    cyc(10);
    chk("n_data", out_data, 16'h1234);
    chk("n_disp", {d1, d2, d3, d4}, {6'b100010, 6'b100100, 6'b100110, 6'b101000});
    entry_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 16'h1234);
    end
    cyc(1);
    transfer(16'h1234);
    @(negedge clock);
    chk("xfer_valid", out_valid, 0);
    chk("xfer_disp", {d1, d2, d3, d4}, 0);

    // 6a: presses in IDLE
    press(7);
    chk("idle_data", out_data, 16'h1234);
    chk("idle_err", err, 0);
    chk("idle_state", {out_valid, d1, d2, d3, d4}, 0);

    // 3: duplicate rejection
    entry_req = 1;
    cyc(2);
    press(5); press(7); press(5);
    chk("dup_err", err, 1);
    chk("dup_d2", d2, 6'b101110);
    chk("dup_d3", d3[4:0], 5'b01011);
    press(9);
    chk("dup_clr", err, 0);
    chk("dup_d3_st", d3, 6'b110010);
    press(4'hA);
    chk("dup_valid", out_valid, 1);
    chk("dup_data", out_data, 16'h579A);

    // 6b: presses in PRESENT
    press(4'hB);
    chk("pres_data", out_data, 16'h579A);
    chk("pres_valid", out_valid, 1);
    chk("pres_err", err, 0);
    chk("pres_d4", d4, 6'b110100);
    entry_req = 0;
    transfer(16'h579A);

    // 4: cursor blink
    entry_req = 1;
    cyc(2);
    press(3);
    code = 4'hF;
    @(negedge clock);
    v = d2;
    n = 0;
    while (d2 === v && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("blink_toggled", (n < 20), 1);
    ph = d2[5];
    for (int k = 0; k < 16; k++) begin
      chk("blink_d2", d2, {(k < 8) ? ph : ~ph, 5'b11110});
      chk("blink_d1", d1, 6'b100110);
      @(negedge clock);
    end

    // 5: abort, re-request, async reset
    cyc(1);
    press(8);
    entry_req = 0;
    cyc(1);
    @(negedge clock);
    chk("abort_disp", {d1, d2, d3, d4}, 0);
    cyc(5);
    chk("abort_valid", out_valid, 0);
    code = 4'hC;
    entry_req = 1;
    cyc(2);
    @(negedge clock);
    chk("rereq_d1", {d1[4:0]}, 5'b11000);
    chk("rereq_d2", d2, 0);
    cyc(1);
    press(1); press(2); press(3); press(4);
    chk("rst_pre_valid", out_valid, 1);
    @(posedge clock);
    #3 reset = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_err", err, 0);
    chk("arst_disp", {d1, d2, d3, d4}, 0);
    cyc(2);
    reset = 1;
    cyc(2);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/entry_ctrl.md
Name: entry_ctrl

Overview:
- Sequences player input for the Bulls & Cows game on the Nexys A7.
- Conditions the raw enter button (synchronise, debounce, edge-detect) and collects four 4-bit digits from the code switches.
- Rejects repeated digits and hands the completed 16-bit entry to the game core over a valid/ready handshake.
- Drives the four entry-field display digits in the 6-bit format consumed by dspl_drv_NexysA7.

Parameters:
DEB_CNT, 1_000_000, consecutive stable cycles required to accept a new debounced button level (10 ms at 100 MHz)
BLINK_CNT, 25_000_000, cycles per half-period of the cursor blink

Ports:
clock  input  1  system clock, single domain
reset  input  1  asynchronous, active-low reset
code  input  4  digit value from switches, sampled on accepted press
enter_button  input  1  raw asynchronous push-button, active-high
entry_req  input  1  level from game core: requests a new 4-digit entry
out_valid  output  1  completed entry available
out_ready  input  1  game core accepts entry
out_data  output  16  entry; digit0 in [15:12] ... digit3 in [3:0]
err  output  1  high while last press was rejected as a duplicate
d1, d2, d3, d4  output  6 each  display digits (d1 = digit0); format: [5] enable, [4:1] hex value, [0] decimal point, all active-high

Behaviour:
- Reset (reset low, asynchronous): state IDLE, index 0, digit regs 0, out_valid 0, out_data 0, err 0, d1..d4 6'b000000, debounced level 0, counters 0, blink flag 1.
- Button conditioning:
  - 2-FF synchroniser produces s.
  - Debounce counter clears whenever s == deb.
  - When s != deb for DEB_CNT consecutive cycles, deb <= s and the counter clears.
  - press = deb & ~deb_q, a one-cycle pulse per debounced rising edge.
  - A release produces no pulse.
- Blink: free-running counter; the blink flag toggles every BLINK_CNT cycles; not reset by state changes.
- State machine:
  - IDLE:
    - d1..d4 all 0; presses ignored.
    - entry_req high -> COLLECT with index 0, digits cleared, err 0.
  - COLLECT:
    - Captured positions (< index) display {1, digit, 0}.
    - Cursor position (== index) displays {blink, code, err}, so the live switch value is shown.
    - Positions > index display 0.
    - On press:
      - If code equals any digit at position < index: reject, set err 1, index unchanged.
      - Otherwise store code at position index, clear err, index+1.
      - When the stored digit was at index 3 -> PRESENT next cycle.
    - entry_req low in COLLECT -> IDLE next cycle (abort, digits discarded, err 0).
  - PRESENT:
    - out_valid 1, out_data stable; d1..d4 show {1, digit, 0} steadily.
    - Presses and entry_req ignored.
    - Transfer occurs on a cycle with out_valid & out_ready; next cycle out_valid 0, state IDLE.
    - out_data holds its value until the next entry completes.
- out_valid rises on the cycle after the 4th accepted press is registered; latency from the 4th press pulse to out_valid = 1 cycle.
- Simultaneous press and entry_req falling in COLLECT: abort wins, press discarded.
- A press pulse in the same cycle as IDLE->COLLECT is ignored.
- The first digit (index 0) is never a duplicate. All 16 values 0-F are legal.
- Reset asserted mid-operation returns to reset values immediately, regardless of state or pending handshake.

Test Plan:
- Common bench setup: DEB_CNT=4, BLINK_CNT=8.
1. Debounce: enter_button toggles every 2 cycles for 20 cycles, then holds high 10 cycles -> exactly one press pulse, no pulse from the glitches; release -> no pulse.
2. Normal entry: entry_req=1; press with code 1, 2, 3, 4 -> out_valid=1 one cycle after 4th press; out_data=16'h1234; d1..d4 = 6'b100010, 6'b100100, 6'b100110, 6'b101000. Hold out_ready=0 for 5 cycles -> valid and data stable; pulse out_ready -> out_valid 0 and IDLE next cycle; d1..d4 = 0.
3. Duplicate rejection: enter 5, 7, then press code 5 -> err=1, index stays 2, d3[0]=1; press 9 -> err=0, digit stored; finish with A -> out_data=16'h579A.
4. Cursor blink: in COLLECT at index 1 with code=F -> d2 alternates between 6'b111110 and 6'b011110 every 8 cycles; d1 steady.
5. Abort and reset: after 2 digits, drop entry_req -> IDLE, d1..d4 0, out_valid never rises. Re-request -> starts at index 0. Assert reset during PRESENT -> out_valid, out_data, err, d1..d4 all 0 immediately (asynchronous).
6. Ignored presses: presses in IDLE and in PRESENT -> no change to out_data, index or err.
